// File: rtl/cpu_module_if.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// one-outstanding req/ready handshake, and drives the IF/ID register.
// A one-entry holding buffer absorbs a response that lands during an ID stall.
// Taken branch / J / JR redirect the fetch and squash the wrong-path slot.
module cpu_module_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_IFWrite,
    input  logic        Branch_taken,
    input  logic        J_Valid,
    input  logic        JR_Valid,
    input  logic [31:0] BranchAddr_id,
    input  logic [31:0] JAddr,
    input  logic [31:0] JRAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] NextPC_id,
    output logic        Valid_id
);

    // Fetch state
    logic [31:0] r_pc;
    logic        r_outstanding;
    logic [31:0] r_out_pc4;
    logic        r_discard;

    // Holding buffer for a response captured while ID is stalled
    logic        r_hold_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc4;

    // IF/ID register
    logic [31:0] r_instr_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_resp;
    logic        w_good;
    logic [31:0] w_fetch;
    logic [31:0] w_addr_pc4;

    // Redirect target selection: JR wins over J, J wins over branch
    always_comb begin
        w_target = BranchAddr_id;
        if (JR_Valid)
            w_target = JRAddr;
        else if (J_Valid)
            w_target = JAddr;
    end

    // A stall from ID masks redirects; ready without a request in flight is noise
    assign w_redirect = PC_IFWrite & (Branch_taken | J_Valid | JR_Valid);
    assign w_resp     = imem_ready & r_outstanding;
    assign w_good     = w_resp & ~r_discard;

    assign w_fetch    = w_redirect ? w_target : r_pc;
    assign imem_addr  = w_fetch & 32'hFFFF_FFFC;
    assign w_addr_pc4 = imem_addr + 32'd4;

    // Re-request in the same cycle as a response keeps zero-wait memory at
    // one instruction per cycle. No request while the buffer is full or while
    // a good response is being parked in it, so the buffer never overflows.
    assign imem_req = ~rst & (~r_outstanding | w_resp) & ~r_hold_valid
                    & ~(w_good & ~PC_IFWrite);

    // PC, in-flight tracking and stale-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_out_pc4     <= 32'd0;
            r_discard     <= 1'b0;
        end else begin
            if (imem_req) begin
                r_outstanding <= 1'b1;
                r_out_pc4     <= w_addr_pc4;
                r_pc          <= w_addr_pc4;
            end else begin
                if (w_resp)
                    r_outstanding <= 1'b0;
                // Target is remembered and fetched once the stale reply drains
                if (w_redirect)
                    r_pc <= w_target;
            end
            if (w_redirect & r_outstanding & ~w_resp)
                r_discard <= 1'b1;
            else if (w_resp)
                r_discard <= 1'b0;
        end
    end

    // Holding buffer: fill on a good response during stall, drain on release,
    // flush on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_instr <= 32'd0;
            r_hold_pc4   <= 32'd0;
        end else if (PC_IFWrite) begin
            if (w_redirect || r_hold_valid)
                r_hold_valid <= 1'b0;
        end else if (w_good) begin
            r_hold_valid <= 1'b1;
            r_hold_instr <= imem_rdata;
            r_hold_pc4   <= r_out_pc4;
        end
    end

    // IF/ID register: bubble on redirect, then buffer, then fresh response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_id <= 32'd0;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (PC_IFWrite) begin
            if (w_redirect) begin
                r_instr_id <= 32'd0;
                r_valid_id <= 1'b0;
            end else if (r_hold_valid) begin
                r_instr_id <= r_hold_instr;
                r_pc4_id   <= r_hold_pc4;
                r_valid_id <= 1'b1;
            end else if (w_good) begin
                r_instr_id <= imem_rdata;
                r_pc4_id   <= r_out_pc4;
                r_valid_id <= 1'b1;
            end else begin
                r_instr_id <= 32'd0;
                r_valid_id <= 1'b0;
            end
        end
    end

    assign Instruction_id = r_instr_id;
    assign NextPC_id      = r_pc4_id;
    assign Valid_id       = r_valid_id;

endmodule

// File: tb/tb_cpu_module_if.sv
// Directed bench for the IF stage: sequential fetch, stall/hold buffer,
// redirects with bubble and stale-response drop, priority, reset, PC wrap.
module tb_cpu_module_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_IFWrite = 1'b1;
    logic        Branch_taken = 1'b0, J_Valid = 1'b0, JR_Valid = 1'b0;
    logic [31:0] BranchAddr_id = 32'd0, JAddr = 32'd0, JRAddr = 32'd0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] Instruction_id, NextPC_id;
    logic        Valid_id;

    // Second instance for the wrap-around case
    logic        rst2 = 1'b1;
    logic        req2, rdy2;
    logic [31:0] addr2, rdata2, instr2, pc4_2;
    logic        valid2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_module_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PC_IFWrite(PC_IFWrite),
        .Branch_taken(Branch_taken), .J_Valid(J_Valid), .JR_Valid(JR_Valid),
        .BranchAddr_id(BranchAddr_id), .JAddr(JAddr), .JRAddr(JRAddr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Instruction_id(Instruction_id), .NextPC_id(NextPC_id), .Valid_id(Valid_id)
    );

    cpu_module_if #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .PC_IFWrite(1'b1),
        .Branch_taken(1'b0), .J_Valid(1'b0), .JR_Valid(1'b0),
        .BranchAddr_id(32'd0), .JAddr(32'd0), .JRAddr(32'd0),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(rdy2), .imem_rdata(rdata2),
        .Instruction_id(instr2), .NextPC_id(pc4_2), .Valid_id(valid2)
    );

    // Memory model: latency 'lat' cycles, returns the address as the data word
    int          lat = 1;
    int          mc = 0;
    logic        mb = 1'b0;
    logic [31:0] ma = 32'd0;
    logic        frc = 1'b0;
    assign imem_ready = (mb && mc == 0) || frc;
    assign imem_rdata = (mb && mc == 0) ? ma : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (rst) mb <= 1'b0;
        else if (imem_req) begin mb <= 1'b1; mc <= lat - 1; ma <= imem_addr; end
        else if (mb && mc == 0) mb <= 1'b0;
        else if (mb) mc <= mc - 1;
    end

    // Zero-wait memory for the second instance
    logic [31:0] ma2 = 32'd0;
    logic        mb2 = 1'b0;
    assign rdy2   = mb2;
    assign rdata2 = ma2;
    always @(posedge clk) begin
        if (rst2) mb2 <= 1'b0;
        else begin mb2 <= req2; ma2 <= addr2; end
    end

    task cyc; @(posedge clk); #1; endtask
    task mid; #3; endtask

    task test_reset;
        cyc; cyc;
        n_chk++;
        if ({imem_req, Instruction_id, NextPC_id, Valid_id} !== {1'b0, 32'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b instr=%h pc4=%h valid=%b required 0/0/0/0",
                     imem_req, Instruction_id, NextPC_id, Valid_id);
        end
        n_chk++;
        if (imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL reset_addr: got %h required 00000000", imem_addr);
        end
        rst = 1'b0;
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL first_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
        cyc;
        n_chk++;
        if (Valid_id !== 1'b0) begin
            n_fail++; $display("FAIL first_slot_bubble: valid=%b required 0", Valid_id);
        end
    endtask

    task test_seq;
        for (int i = 1; i <= 4; i++) begin
            mid;
            n_chk++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
                n_fail++; $display("FAIL seq_req[%0d]: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, 32'(4 * i));
            end
            cyc;
            n_chk++;
            if ({Instruction_id, NextPC_id, Valid_id} !== {32'(4 * (i - 1)), 32'(4 * i), 1'b1}) begin
                n_fail++; $display("FAIL seq_ifid[%0d]: got %h/%h/%b required %h/%h/1", i,
                                   Instruction_id, NextPC_id, Valid_id, 32'(4 * (i - 1)), 32'(4 * i));
            end
        end
    endtask

    task test_stall;
        PC_IFWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid;
            n_chk++;
            if (imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_req[%0d]: got %b required 0", i, imem_req);
            end
            cyc;
            n_chk++;
            if ({Instruction_id, NextPC_id, Valid_id} !== {32'h0C, 32'h10, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h/%h/%b required 0000000c/00000010/1",
                                   i, Instruction_id, NextPC_id, Valid_id);
            end
        end
        PC_IFWrite = 1'b1;
        mid;
        n_chk++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL release_req: got %b required 0", imem_req);
        end
        cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h10, 32'h14, 1'b1}) begin
            n_fail++; $display("FAIL release_ifid: got %h/%h/%b required 00000010/00000014/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h14}) begin
            n_fail++; $display("FAIL resume_req: req=%b addr=%h required 1/00000014", imem_req, imem_addr);
        end
        cyc;
        n_chk++;
        if (Valid_id !== 1'b0) begin
            n_fail++; $display("FAIL resume_bubble: valid=%b required 0", Valid_id);
        end
        mid; cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h14, 32'h18, 1'b1}) begin
            n_fail++; $display("FAIL resume_ifid: got %h/%h/%b required 00000014/00000018/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
    endtask

    task test_branch;
        Branch_taken = 1'b1; BranchAddr_id = 32'h100;
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL branch_req: req=%b addr=%h required 1/00000100", imem_req, imem_addr);
        end
        cyc;
        Branch_taken = 1'b0;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h0, 32'h18, 1'b0}) begin
            n_fail++; $display("FAIL branch_bubble: got %h/%h/%b required 00000000/00000018/0",
                               Instruction_id, NextPC_id, Valid_id);
        end
        mid; cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h100, 32'h104, 1'b1}) begin
            n_fail++; $display("FAIL branch_target: got %h/%h/%b required 00000100/00000104/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
    endtask

    task test_jr_latency;
        lat = 3;
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
            n_fail++; $display("FAIL lat_req: req=%b addr=%h required 1/00000108", imem_req, imem_addr);
        end
        cyc;
        JR_Valid = 1'b1; JRAddr = 32'h200;
        mid;
        n_chk++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL jr_pending_req: got %b required 0", imem_req);
        end
        cyc;
        JR_Valid = 1'b0;
        n_chk++;
        if (Valid_id !== 1'b0) begin
            n_fail++; $display("FAIL jr_bubble: valid=%b required 0", Valid_id);
        end
        mid; cyc;
        mid;
        n_chk++;
        if ({imem_ready, imem_req, imem_addr} !== {1'b1, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL jr_reissue: rdy=%b req=%b addr=%h required 1/1/00000200",
                               imem_ready, imem_req, imem_addr);
        end
        cyc;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (Valid_id !== 1'b0) begin
                n_fail++; $display("FAIL jr_stale_dropped[%0d]: valid=%b instr=%h required 0", i, Valid_id, Instruction_id);
            end
            if (i == 2) lat = 1;
            mid; cyc;
        end
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h200, 32'h204, 1'b1}) begin
            n_fail++; $display("FAIL jr_target: got %h/%h/%b required 00000200/00000204/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
    endtask

    task test_priority;
        JR_Valid = 1'b1; J_Valid = 1'b1; Branch_taken = 1'b1;
        JRAddr = 32'h300; JAddr = 32'h400; BranchAddr_id = 32'h500;
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
            n_fail++; $display("FAIL prio_req: req=%b addr=%h required 1/00000300", imem_req, imem_addr);
        end
        cyc;
        JR_Valid = 1'b0; J_Valid = 1'b0; Branch_taken = 1'b0;
        mid; cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h300, 32'h304, 1'b1}) begin
            n_fail++; $display("FAIL prio_target: got %h/%h/%b required 00000300/00000304/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
        PC_IFWrite = 1'b0;
        JR_Valid = 1'b1; J_Valid = 1'b1; Branch_taken = 1'b1;
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h308}) begin
            n_fail++; $display("FAIL prio_stall_ignored: req=%b addr=%h required 0/00000308", imem_req, imem_addr);
        end
        cyc;
        JR_Valid = 1'b0; J_Valid = 1'b0; Branch_taken = 1'b0;
        PC_IFWrite = 1'b1;
        mid; cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h304, 32'h308, 1'b1}) begin
            n_fail++; $display("FAIL prio_stall_held: got %h/%h/%b required 00000304/00000308/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
        mid;
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h308}) begin
            n_fail++; $display("FAIL prio_pc_kept: req=%b addr=%h required 1/00000308", imem_req, imem_addr);
        end
        cyc;
    endtask

    task test_rst_mid;
        rst = 1'b1;
        mid;
        n_chk++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_req: got %b required 0", imem_req);
        end
        cyc;
        n_chk++;
        if ({imem_addr, Instruction_id, NextPC_id, Valid_id} !== {32'd0, 32'd0, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL rst_mid_state: addr=%h instr=%h pc4=%h valid=%b required all 0",
                               imem_addr, Instruction_id, NextPC_id, Valid_id);
        end
        rst = 1'b0; frc = 1'b1;
        mid; cyc;
        frc = 1'b0;
        n_chk++;
        if ({Instruction_id, Valid_id} !== {32'd0, 1'b0}) begin
            n_fail++; $display("FAIL late_ready_ignored: instr=%h valid=%b required 00000000/0", Instruction_id, Valid_id);
        end
        mid; cyc;
        n_chk++;
        if ({Instruction_id, NextPC_id, Valid_id} !== {32'h0, 32'h4, 1'b1}) begin
            n_fail++; $display("FAIL rst_refetch: got %h/%h/%b required 00000000/00000004/1",
                               Instruction_id, NextPC_id, Valid_id);
        end
    endtask

    task test_wrap;
        rst2 = 1'b0;
        mid;
        n_chk++;
        if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_first: req=%b addr=%h required 1/fffffffc", req2, addr2);
        end
        cyc;
        mid;
        n_chk++;
        if ({req2, addr2} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_second: req=%b addr=%h required 1/00000000", req2, addr2);
        end
        cyc;
        n_chk++;
        if ({instr2, pc4_2, valid2} !== {32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_ifid: got %h/%h/%b required fffffffc/00000000/1", instr2, pc4_2, valid2);
        end
        mid; cyc;
        n_chk++;
        if ({instr2, pc4_2, valid2} !== {32'h0, 32'h4, 1'b1}) begin
            n_fail++; $display("FAIL wrap_next: got %h/%h/%b required 00000000/00000004/1", instr2, pc4_2, valid2);
        end
    endtask

    initial begin
        test_reset;
        test_seq;
        test_stall;
        test_branch;
        test_jr_latency;
        test_priority;
        test_rst_mid;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
